// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, FSM encodings and exception helpers for hazard_ctrl
package hazard_pkg;
  localparam int RA_W_DEF = 5;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE = 32'h0000000E;
  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;
  typedef enum logic {EX_IDLE, EX_PEND} ex_state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] FWD_W = 2'b11;
  localparam logic [1:0] FWD_EW = 2'b01;
  function automatic logic exc_takes(input logic [31:0] c);
    return c == ERET_CODE || c inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC};
  endfunction
  function automatic logic [31:0] exc_target(input logic [31:0] c, input logic [31:0] epc);
    return c == ERET_CODE ? epc : EXC_VEC;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return c + 32'(en && c != '1);
  endfunction
endpackage

// File: rtl/hazard_ctrl_exc_redirect_fsm.sv
// exc_redirect_fsm: holds an exception redirect across cache stalls and fires it once
module exc_redirect_fsm
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        cs,
  input  logic [31:0] excepttype_m,
  input  logic [31:0] epc_m,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  ex_state_e state;
  logic [31:0] target;
  logic take;
  assign take = exc_takes(excepttype_m);
  assign redirect = resetn & ~cs & (state == EX_PEND | take);
  assign redirect_pc = state == EX_PEND ? target : exc_target(excepttype_m, epc_m);
  // PEND waits out the cache stall; new exceptions are ignored while pending
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= EX_IDLE;
      target <= '0;
    end else if (state == EX_PEND) begin
      if (!cs) state <= EX_IDLE;
    end else if (take && cs) begin
      state <= EX_PEND;
      target <= exc_target(excepttype_m, epc_m);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall/flush and redirect control for the 5-stage core (optional HAZARD_PERF_EN counters)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W = RA_W_DEF,
  parameter int NRP = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRP*RA_W-1:0] src_d,
  input  logic [NRP*RA_W-1:0] src_e,
  input  logic              branch_d,
  input  logic              load_d,
  input  logic [RA_W-1:0]   wreg_e,
  input  logic [RA_W-1:0]   wreg_m,
  input  logic [RA_W-1:0]   wreg_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              load_e,
  input  logic              load_m,
  input  logic              mc_start_e,
  input  logic              mc_done,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic [31:0]       excepttype_m,
  input  logic [31:0]       epc_m,
  output logic [NRP*2-1:0]  fwd_d,
  output logic [NRP*2-1:0]  fwd_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_f,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              redirect,
  output logic [31:0]       redirect_pc
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_cs_cyc,
  output logic [31:0]       perf_lu_cyc,
  output logic [31:0]       perf_mc_cyc,
  output logic [31:0]       perf_redirects
`endif
);
  logic [NRP-1:0] hit_e, hit_m;
  logic cs, lu, br, mc, unused_load_d;
  mc_state_e mc_state;
  assign unused_load_d = load_d;
  for (genvar i = 0; i < NRP; i++) begin : g_port
    logic [RA_W-1:0] sd, se;
    logic de, dm, dw, em, ew;
    assign sd = src_d[i*RA_W +: RA_W];
    assign se = src_e[i*RA_W +: RA_W];
    assign de = (|sd) & (sd == wreg_e);
    assign dm = (|sd) & (sd == wreg_m);
    assign dw = (|sd) & (sd == wreg_w);
    assign em = (|se) & (se == wreg_m);
    assign ew = (|se) & (se == wreg_w);
    assign fwd_d[2*i +: 2] = de & regwrite_e ? FWD_E : dm & regwrite_m ? FWD_M : dw & regwrite_w ? FWD_W : FWD_RF;
    assign fwd_e[2*i +: 2] = em & regwrite_m ? FWD_M : ew & regwrite_w ? FWD_EW : FWD_RF;
    assign hit_e[i] = de;
    assign hit_m[i] = dm;
  end
  assign cs = i_stall | d_stall;
  assign lu = load_e & regwrite_e & |hit_e;
  assign br = branch_d & ((regwrite_e & |hit_e) | (load_m & |hit_m));
  assign mc = (mc_state == MC_BUSY | mc_start_e) & ~mc_done;
  assign stall_m = cs & ~redirect;
  assign stall_w = stall_m;
  assign stall_e = (cs | mc) & ~redirect;
  assign stall_d = (cs | mc | lu | br) & ~redirect;
  assign stall_f = stall_d;
  assign flush_f = redirect;
  assign flush_d = redirect;
  assign flush_e = redirect | (lu & ~cs & ~mc);
  assign flush_m = redirect;
  assign flush_w = redirect;
  // multi-cycle unit is busy while an op is outstanding; a redirect abandons it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) mc_state <= MC_IDLE;
    else mc_state <= mc & ~redirect ? MC_BUSY : MC_IDLE;
  exc_redirect_fsm u_exc (
    .clk(clk),
    .resetn(resetn),
    .cs(cs),
    .excepttype_m(excepttype_m),
    .epc_m(epc_m),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );
`ifdef HAZARD_PERF_EN
  // saturating event counters
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      perf_cs_cyc <= '0;
      perf_lu_cyc <= '0;
      perf_mc_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      perf_cs_cyc <= sat_inc(perf_cs_cyc, cs);
      perf_lu_cyc <= sat_inc(perf_lu_cyc, lu);
      perf_mc_cyc <= sat_inc(perf_mc_cyc, mc);
      perf_redirects <= sat_inc(perf_redirects, redirect);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int RA_W = 5;
  localparam int NRP = 2;
  logic clk = 0, resetn = 0;
  logic [NRP*RA_W-1:0] src_d, src_e;
  logic branch_d, load_d, regwrite_e, regwrite_m, regwrite_w, load_e, load_m;
  logic [RA_W-1:0] wreg_e, wreg_m, wreg_w;
  logic mc_start_e, mc_done, i_stall, d_stall;
  logic [31:0] excepttype_m, epc_m, redirect_pc;
  logic [NRP*2-1:0] fwd_d, fwd_e;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_f, flush_d, flush_e, flush_m, flush_w, redirect;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_cs_cyc, perf_lu_cyc, perf_mc_cyc, perf_redirects;
`endif
  int checks = 0, errors = 0;
  bit m_busy, m_pend, n_busy, n_pend;
  logic [31:0] m_pc, n_pc;
  logic e_redir;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .NRP(NRP)) dut (
    .clk(clk), .resetn(resetn), .src_d(src_d), .src_e(src_e), .branch_d(branch_d), .load_d(load_d),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .load_m(load_m), .mc_start_e(mc_start_e), .mc_done(mc_done),
    .i_stall(i_stall), .d_stall(d_stall), .excepttype_m(excepttype_m), .epc_m(epc_m),
    .fwd_d(fwd_d), .fwd_e(fwd_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef HAZARD_PERF_EN
    , .perf_cs_cyc(perf_cs_cyc), .perf_lu_cyc(perf_lu_cyc), .perf_mc_cyc(perf_mc_cyc),
    .perf_redirects(perf_redirects)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit reads(input logic [RA_W-1:0] s, input logic [RA_W-1:0] w);
    return s != 0 && s == w;
  endfunction

  function automatic bit code_ok(input logic [31:0] c);
    int unsigned vec_codes[7] = '{1, 4, 5, 8, 9, 10, 12};
    if (c == 32'hE) return 1;
    foreach (vec_codes[k]) if (c == vec_codes[k]) return 1;
    return 0;
  endfunction

  // model the whole controller from the rules, compare, and prepare the next model state
  task automatic settle();
    logic [NRP*2-1:0] xd, xe;
    logic [RA_W-1:0] dst[3];
    bit wr[3], lu, br, mc, cs, ok;
    logic [4:0] xs;
    logic [31:0] tgt;
    #1;
    dst = '{wreg_e, wreg_m, wreg_w};
    wr = '{regwrite_e, regwrite_m, regwrite_w};
    xd = '0;
    xe = '0;
    lu = 0;
    br = 0;
    for (int p = 0; p < NRP; p++) begin
      logic [RA_W-1:0] s, t;
      s = src_d[p*RA_W +: RA_W];
      t = src_e[p*RA_W +: RA_W];
      for (int k = 2; k >= 0; k--) if (wr[k] && reads(s, dst[k])) xd[2*p +: 2] = 2'(k + 1);
      if (regwrite_w && reads(t, wreg_w)) xe[2*p +: 2] = 2'b01;
      if (regwrite_m && reads(t, wreg_m)) xe[2*p +: 2] = 2'b10;
      if (reads(s, wreg_e) && regwrite_e) begin
        if (load_e) lu = 1;
        if (branch_d) br = 1;
      end
      if (branch_d && load_m && reads(s, wreg_m)) br = 1;
    end
    cs = i_stall || d_stall;
    mc = (m_busy || mc_start_e) && !mc_done;
    ok = code_ok(excepttype_m);
    tgt = excepttype_m == 32'hE ? epc_m : 32'hBFC00380;
    e_redir = m_pend ? !cs : ok && !cs;
    xs = e_redir ? 5'b0 : {cs || mc || lu || br, cs || mc || lu || br, cs || mc, cs, cs};
    chk("fwd_d", 32'(fwd_d), 32'(xd));
    chk("fwd_e", 32'(fwd_e), 32'(xe));
    chk("stall_fdemw", 32'({stall_f, stall_d, stall_e, stall_m, stall_w}), 32'(xs));
    chk("flush_fdemw", 32'({flush_f, flush_d, flush_e, flush_m, flush_w}),
        32'({e_redir, e_redir, e_redir || (lu && !cs && !mc), e_redir, e_redir}));
    chk("redirect", 32'(redirect), 32'(e_redir));
    if (e_redir) chk("redirect_pc", redirect_pc, m_pend ? m_pc : tgt);
    n_busy = e_redir || mc_done ? 0 : mc_start_e ? 1 : m_busy;
    n_pend = m_pend;
    n_pc = m_pc;
    if (m_pend) begin
      if (!cs) n_pend = 0;
    end else if (ok && cs) begin
      n_pend = 1;
      n_pc = tgt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_busy = n_busy;
    m_pend = n_pend;
    m_pc = n_pc;
    @(negedge clk);
  endtask

  task automatic clr();
    src_d = '0; src_e = '0; branch_d = 0; load_d = 0;
    wreg_e = '0; wreg_m = '0; wreg_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; load_e = 0; load_m = 0;
    mc_start_e = 0; mc_done = 0; i_stall = 0; d_stall = 0;
    excepttype_m = '0; epc_m = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_pc = '0;
  endtask

  initial begin
    int cnt, nred, at;
    logic [31:0] pool[12] = '{1, 2, 3, 4, 5, 8, 9, 10, 12, 14, 16, 32'h8000000E};
    clr();
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    settle();
    chk("reset_redirect", 32'(redirect), 0);
    chk("reset_stall_d", 32'(stall_d), 0);
    tick();
    // RAW distance 1/2/3 and $0
    regwrite_e = 1; wreg_e = 3; src_d = 10'd3;
    settle(); chk("raw_e", 32'(fwd_d[1:0]), 1); tick();
    clr(); regwrite_m = 1; wreg_m = 3; src_d = 10'd3; src_e = 10'd3;
    settle(); chk("raw_m", 32'(fwd_d[1:0]), 2); chk("raw_e_m", 32'(fwd_e[1:0]), 2); tick();
    clr(); regwrite_w = 1; wreg_w = 3; src_d = 10'd3;
    settle(); chk("raw_w", 32'(fwd_d[1:0]), 3); tick();
    clr(); regwrite_e = 1; regwrite_m = 1; wreg_e = 0; wreg_m = 0;
    settle(); chk("raw_zero", 32'(fwd_d), 0); tick();
    // load-use via port 1
    clr(); load_e = 1; regwrite_e = 1; wreg_e = 5; src_d = {5'd5, 5'd0};
    settle(); chk("lu_stall", 32'({stall_f, stall_d}), 3); chk("lu_flush_e", 32'(flush_e), 1); tick();
    clr();
    settle(); chk("lu_after", 32'({stall_d, flush_e}), 0); tick();
    load_e = 1; regwrite_e = 1; wreg_e = 5; src_d = {5'd5, 5'd0}; d_stall = 1;
    settle(); chk("lu_dstall_flush_e", 32'(flush_e), 0); tick();
    // 34-cycle multi-cycle op
    clr(); mc_start_e = 1; cnt = 0;
    settle(); cnt += int'(stall_e); tick();
    mc_start_e = 0;
    for (int k = 1; k < 34; k++) begin settle(); cnt += int'(stall_e); tick(); end
    mc_done = 1;
    settle(); chk("mc_done_stall_e", 32'(stall_e), 0); chk("mc_cycles", cnt, 34); tick();
    mc_start_e = 1;
    settle(); chk("mc_zero_stall", 32'(stall_e), 0); tick();
    clr();
    settle(); chk("mc_zero_after", 32'(stall_e), 0); tick();
    // exception during a 5-cycle I-stall
    nred = 0; at = 0;
    for (int c = 1; c <= 7; c++) begin
      excepttype_m = c <= 5 ? 32'h8 : 32'h0;
      i_stall = c <= 5;
      settle();
      if (redirect) begin
        nred++; at = c;
        chk("exc_pc", redirect_pc, 32'hBFC00380);
        chk("exc_flush", 32'({flush_f, flush_d, flush_e, flush_m, flush_w}), 5'b11111);
      end
      tick();
    end
    chk("exc_count", nred, 1);
    chk("exc_cycle", at, 6);
    // ERET and ignored code
    clr(); excepttype_m = 32'hE; epc_m = 32'h80001234;
    settle(); chk("eret_redirect", 32'(redirect), 1); chk("eret_pc", redirect_pc, 32'h80001234); tick();
    clr(); excepttype_m = 32'h3;
    settle(); chk("code3_redirect", 32'(redirect), 0); tick();
    // reset during PEND discards the redirect
    clr(); excepttype_m = 32'h8; d_stall = 1;
    settle(); tick();
    resetn = 0; #2; resetn = 1; model_reset();
    clr();
    settle(); chk("pend_reset_redirect", 32'(redirect), 0); tick();
`ifdef HAZARD_PERF_EN
    resetn = 0; #2; resetn = 1; model_reset();
    d_stall = 1;
    for (int k = 0; k < 10; k++) begin settle(); tick(); end
    clr();
    settle(); chk("perf_cs_cyc", perf_cs_cyc, 10); tick();
`endif
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NRP; p++) begin
        src_d[p*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
        src_e[p*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
      end
      wreg_e = RA_W'($urandom_range(0, 3));
      wreg_m = RA_W'($urandom_range(0, 3));
      wreg_w = RA_W'($urandom_range(0, 3));
      {regwrite_e, regwrite_m, regwrite_w, load_e, load_m, branch_d, load_d} = 7'($urandom);
      mc_start_e = $urandom_range(0, 9) == 0;
      mc_done = $urandom_range(0, 9) == 0;
      i_stall = $urandom_range(0, 3) == 0;
      d_stall = $urandom_range(0, 3) == 0;
      excepttype_m = $urandom_range(0, 7) == 0 ? pool[$urandom_range(0, 11)] : 32'h0;
      epc_m = $urandom;
      settle();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
